// File: rtl/nn_layer_sequencer.sv
// Layer sequencer for the bit-serial neural engine: loads an input vector into a ping-pong
// activation buffer, starts the MAC once per layer, requantises results between layers and streams the last.
module nn_layer_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_MAX  = 128,
  parameter int unsigned L_MAX  = 4,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned ACC_W  = 2*DATA_W + $clog2(N_MAX)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_wr_en,
  input  logic [$clog2(L_MAX)-1:0]     cfg_layer,
  input  logic [$clog2(N_MAX+1)-1:0]   cfg_n_out,
  input  logic [1:0]                   cfg_act,
  input  logic [$clog2(L_MAX+1)-1:0]   cfg_n_layers,
  input  logic [DATA_W-1:0]            s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic                         mac_start,
  output logic [$clog2(L_MAX)-1:0]     mac_layer,
  output logic [$clog2(N_MAX+1)-1:0]   mac_n_in,
  output logic [$clog2(N_MAX+1)-1:0]   mac_n_out,
  input  logic [$clog2(N_MAX)-1:0]     vec_raddr,
  output logic [DATA_W-1:0]            vec_rdata,
  input  logic [ACC_W-1:0]             res_tdata,
  input  logic                         res_tvalid,
  output logic                         res_tready,
  output logic [ACC_W-1:0]             m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         busy,
  output logic                         err_ovf
);

  localparam int unsigned LW  = $clog2(L_MAX);
  localparam int unsigned NW  = $clog2(N_MAX+1);
  localparam int unsigned AW  = $clog2(N_MAX);
  localparam int unsigned NLW = $clog2(L_MAX+1);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} state_t;

  state_t                   state, state_nx;
  logic [NW-1:0]            n_out_tbl [L_MAX];
  logic [1:0]               act_tbl   [L_MAX];
  logic [LW-1:0]            layer, last_layer;
  logic [NW-1:0]            in_cnt, res_cnt;
  logic [DATA_W-1:0]        mem [2*N_MAX];

  logic                     in_fire, res_fire, in_room, is_final, res_last, cfg_we;
  logic [NW-1:0]            n_out_clamp;
  logic [NLW-1:0]           nl_c;
  logic signed [ACC_W-1:0]  res_s, act_val, shr;
  logic [DATA_W-1:0]        q_val;
  logic                     wr_en;
  logic [AW:0]              wr_addr;
  logic [DATA_W-1:0]        wr_data;

  assign in_fire  = s_axis_tvalid && s_axis_tready;
  assign res_fire = res_tvalid && res_tready;
  assign in_room  = in_cnt < NW'(N_MAX);
  assign is_final = (layer == last_layer);
  assign res_last = (res_cnt == NW'(mac_n_out - NW'(1)));
  assign mac_layer = layer;

  // Config is frozen from the first accepted beat onward, including that beat's own cycle.
  assign cfg_we = cfg_wr_en && !busy && !(state == IDLE && s_axis_tvalid);
  assign n_out_clamp = (cfg_n_out == '0) ? NW'(1) :
                       (cfg_n_out > NW'(N_MAX)) ? NW'(N_MAX) : cfg_n_out;
  assign nl_c = (cfg_n_layers == '0) ? NLW'(1) :
                (cfg_n_layers > NLW'(L_MAX)) ? NLW'(L_MAX) : cfg_n_layers;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_fire) state_nx = s_axis_tlast ? START : LOAD;
      LOAD:    if (in_fire && s_axis_tlast) state_nx = START;
      START:   state_nx = RUN;
      RUN:     if (res_fire && res_last) state_nx = is_final ? DRAIN : START;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    mac_start     = 1'b0;
    busy          = 1'b0;
    res_tready    = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    case (state)
      IDLE: s_axis_tready = 1'b1;
      LOAD: begin
        s_axis_tready = 1'b1;
        busy          = 1'b1;
      end
      START: begin
        mac_start = 1'b1;
        busy      = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
        if (is_final) begin
          res_tready    = m_axis_tready;
          m_axis_tvalid = res_tvalid;
          m_axis_tlast  = res_tvalid && res_last;
          m_axis_tdata  = act_val;
        end else begin
          res_tready = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Activation, then requantise and saturate to a signed DATA_W activation.
  always_comb begin
    res_s   = $signed(res_tdata);
    act_val = res_s;
    if (res_s[ACC_W-1]) begin
      case (act_tbl[layer])
        2'd0:    act_val = res_s;
        2'd2:    act_val = res_s >>> 3;
        default: act_val = '0;
      endcase
    end
    shr = act_val >>> FRAC_W;
    if ((&shr[ACC_W-1:DATA_W-1]) || !(|shr[ACC_W-1:DATA_W-1]))
      q_val = shr[DATA_W-1:0];
    else if (shr[ACC_W-1])
      q_val = {1'b1, {(DATA_W-1){1'b0}}};
    else
      q_val = {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer      <= '0;
      last_layer <= '0;
      in_cnt     <= '0;
      res_cnt    <= '0;
      mac_n_in   <= '0;
      mac_n_out  <= '0;
      err_ovf    <= 1'b0;
      for (int i = 0; i < int'(L_MAX); i++) begin
        n_out_tbl[i] <= NW'(1);
        act_tbl[i]   <= 2'd0;
      end
    end else begin
      if (cfg_we) begin
        n_out_tbl[cfg_layer] <= n_out_clamp;
        act_tbl[cfg_layer]   <= cfg_act;
      end
      if (in_fire) begin
        if (state == IDLE) last_layer <= LW'(nl_c - NLW'(1));
        if (in_room) in_cnt <= in_cnt + NW'(1);
        else         err_ovf <= 1'b1;
      end
      if (res_fire) res_cnt <= res_last ? '0 : res_cnt + NW'(1);
      // Entering START: the next layer's input count is the previous layer's output count.
      if (state_nx == START) begin
        if (state == RUN) begin
          layer     <= layer + LW'(1);
          mac_n_in  <= mac_n_out;
          mac_n_out <= n_out_tbl[layer + LW'(1)];
        end else begin
          layer     <= '0;
          mac_n_in  <= in_room ? in_cnt + NW'(1) : NW'(N_MAX);
          mac_n_out <= n_out_tbl[0];
        end
      end
      if (state == DRAIN) begin
        layer     <= '0;
        in_cnt    <= '0;
        mac_n_in  <= '0;
        mac_n_out <= '0;
      end
    end
  end

  // Single write port: input load into bank 0, or requantised results into the bank not being read.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (in_fire && in_room) begin
      wr_en   = 1'b1;
      wr_addr = {1'b0, in_cnt[AW-1:0]};
      wr_data = s_axis_tdata;
    end else if (res_fire && !is_final) begin
      wr_en   = 1'b1;
      wr_addr = {~layer[0], res_cnt[AW-1:0]};
      wr_data = q_val;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          vec_rdata <= '0;
    else if (NW'(vec_raddr) < mac_n_in) vec_rdata <= mem[{layer[0], vec_raddr}];
    else                              vec_rdata <= '0;
  end

endmodule
